// File: rtl/vdu_crtc_pkg.sv
// Shared definitions for the CRTC front-end: register indices, cursor-off bit,
// the conversion FSM state type and the VDU position word packing.
package vdu_crtc_pkg;

  localparam logic [4:0] CRTC_CUR_START = 5'h0A;
  localparam logic [4:0] CRTC_CUR_END   = 5'h0B;
  localparam logic [4:0] CRTC_START_HI  = 5'h0C;
  localparam logic [4:0] CRTC_START_LO  = 5'h0D;
  localparam logic [4:0] CRTC_CUR_HI    = 5'h0E;
  localparam logic [4:0] CRTC_CUR_LO    = 5'h0F;

  localparam int unsigned CRTC_CUR_OFF_BIT = 5;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    WRITE,
    DONE
  } crtc_state_t;

  // {row[4:0], col[6:0]} -> VDU cursor-position word {3'b0, row, 1'b0, col}
  function automatic logic [15:0] pack_pos(input logic [11:0] pos);
    return {3'b000, pos[11:7], 1'b0, pos[6:0]};
  endfunction

endpackage

// File: rtl/vdu_crtc_div80.sv
// 8-step restoring divider of a 14-bit linear cursor address by COLS.
// i_start loads the dividend; o_done pulses for one cycle after the last step,
// after which o_quotient/o_remainder stay stable until the next i_start.
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_start        load dividend and begin (k = 7 .. 0)
//   i_dividend     14-bit linear address
//   o_done         one-cycle completion pulse
//   o_quotient     8-bit quotient (row before saturation)
//   o_remainder    7-bit remainder (column)
module vdu_crtc_div80 #(
  parameter logic [6:0] COLS = 7'd80
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [13:0] i_dividend,
  output logic        o_done,
  output logic [7:0]  o_quotient,
  output logic [6:0]  o_remainder
);

  logic [13:0] r_rem;
  logic [7:0]  r_q;
  logic [2:0]  r_k;
  logic        r_busy;
  logic        r_done;
  logic [13:0] w_sub;

  assign w_sub = {7'b0000000, COLS} << r_k;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_k    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= i_dividend;
        r_q    <= '0;
        r_k    <= 3'd7;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (r_rem >= w_sub) begin
          r_rem    <= r_rem - w_sub;
          r_q[r_k] <= 1'b1;
        end
        if (r_k == 3'd0) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_k <= r_k - 3'd1;
        end
      end
    end
  end

  assign o_done      = r_done;
  assign o_quotient  = r_q;
  assign o_remainder = r_rem[6:0];

endmodule

// File: rtl/vdu_crtc.sv
// 6845-style CRTC register front-end for the text-mode VDU.
// Slave side decodes index/data writes (0x3D4/0x3D5 on byte lanes 0/1) and
// holds cursor shape, start address and cursor address. A write to R0A, R0E
// or R0F schedules a row/column conversion that is pushed to the VDU
// cursor-position register as a Wishbone master write (tag = 1).
//   wb_*        CPU slave port: wb_dat_o = {data_reg[index], 3'b0, index}
//   vdu_*       master port to VDU: vdu_dat_o = {3'b0, row, 1'b0, col}
//   cursor_start_o / cursor_end_o / start_addr_o   register outputs
//   busy_o      high whenever the conversion FSM is not idle
module vdu_crtc
  import vdu_crtc_pkg::*;
#(
  parameter logic [6:0]  COLS     = 7'd80,
  parameter logic [11:0] HIDE_POS = 12'hFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic [15:0] vdu_dat_o,
  output logic        vdu_we_o,
  output logic        vdu_tga_o,
  output logic [1:0]  vdu_sel_o,
  output logic        vdu_stb_o,
  output logic        vdu_cyc_o,
  input  logic        vdu_ack_i,
  output logic [4:0]  cursor_start_o,
  output logic [4:0]  cursor_end_o,
  output logic [13:0] start_addr_o,
  output logic        busy_o
);

  logic [4:0]  r_index;
  logic [5:0]  r_r0a;
  logic [4:0]  r_r0b;
  logic [5:0]  r_r0c;
  logic [7:0]  r_r0d;
  logic [5:0]  r_r0e;
  logic [7:0]  r_r0f;
  logic        r_ack;
  logic        r_pending;
  logic [15:0] r_vdu_dat;
  crtc_state_t r_state;

  crtc_state_t w_next;
  logic        w_req;
  logic        w_wr;
  logic [4:0]  w_idx;
  logic        w_dwr;
  logic        w_trig;
  logic        w_start;
  logic        w_div_done;
  logic [7:0]  w_q;
  logic [6:0]  w_rem;
  logic [11:0] w_pos;
  logic [7:0]  w_rdata;
  logic        w_unused_idx_hi;

  // Index lane carries 8 bits but only 5 address the register file.
  assign w_unused_idx_hi = ^wb_dat_i[7:5];

  // Slave decode; a two-lane write targets the newly written index.
  assign w_req  = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_wr   = w_req & wb_we_i;
  assign w_idx  = (w_wr & wb_sel_i[0]) ? wb_dat_i[4:0] : r_index;
  assign w_dwr  = w_wr & wb_sel_i[1];
  assign w_trig = w_dwr & ((w_idx == CRTC_CUR_START) |
                           (w_idx == CRTC_CUR_HI) |
                           (w_idx == CRTC_CUR_LO));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack   <= 1'b0;
      r_index <= '0;
      r_r0a   <= '0;
      r_r0b   <= '0;
      r_r0c   <= '0;
      r_r0d   <= '0;
      r_r0e   <= '0;
      r_r0f   <= '0;
    end else begin
      r_ack <= w_req;
      if (w_wr & wb_sel_i[0]) begin
        r_index <= wb_dat_i[4:0];
      end
      if (w_dwr) begin
        case (w_idx)
          CRTC_CUR_START: r_r0a <= wb_dat_i[13:8];
          CRTC_CUR_END:   r_r0b <= wb_dat_i[12:8];
          CRTC_START_HI:  r_r0c <= wb_dat_i[13:8];
          CRTC_START_LO:  r_r0d <= wb_dat_i[15:8];
          CRTC_CUR_HI:    r_r0e <= wb_dat_i[13:8];
          CRTC_CUR_LO:    r_r0f <= wb_dat_i[15:8];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (r_index)
      CRTC_CUR_START: w_rdata = {2'b00, r_r0a};
      CRTC_CUR_END:   w_rdata = {3'b000, r_r0b};
      CRTC_START_HI:  w_rdata = {2'b00, r_r0c};
      CRTC_START_LO:  w_rdata = r_r0d;
      CRTC_CUR_HI:    w_rdata = {2'b00, r_r0e};
      CRTC_CUR_LO:    w_rdata = r_r0f;
      default:        w_rdata = '0;
    endcase
  end

  assign wb_dat_o = {w_rdata, 3'b000, r_index};
  assign wb_ack_o = r_ack;

  // A trigger arriving in the same cycle the FSM consumes pending must survive,
  // since the divider already latched the pre-write address.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_pending <= 1'b0;
    end else if (w_trig) begin
      r_pending <= 1'b1;
    end else if (w_start) begin
      r_pending <= 1'b0;
    end
  end

  vdu_crtc_div80 #(.COLS(COLS)) u_div (
    .i_clk       (wb_clk_i),
    .i_rst       (wb_rst_i),
    .i_start     (w_start),
    .i_dividend  ({r_r0e, r_r0f}),
    .o_done      (w_div_done),
    .o_quotient  (w_q),
    .o_remainder (w_rem)
  );

  always_comb begin
    w_pos = {w_q[4:0], w_rem};
    if (r_r0a[CRTC_CUR_OFF_BIT]) begin
      w_pos = HIDE_POS;
    end else if (w_q > 8'd31) begin
      w_pos = {5'd31, 7'd0};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_vdu_dat <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == DIV) && w_div_done) begin
        r_vdu_dat <= pack_pos(w_pos);
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pending) begin
          w_start = 1'b1;
          w_next  = DIV;
        end
      end
      DIV:     if (w_div_done) w_next = WRITE;
      WRITE:   if (vdu_ack_i)  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Strobe is gated by reset so an aborted write drops in the reset cycle itself.
  assign vdu_stb_o = (r_state == WRITE) & ~wb_rst_i;
  assign vdu_cyc_o = vdu_stb_o;
  assign vdu_we_o  = vdu_stb_o;
  assign vdu_tga_o = 1'b1;
  assign vdu_sel_o = 2'b11;
  assign vdu_dat_o = r_vdu_dat;
  assign busy_o    = (r_state != IDLE);

  assign cursor_start_o = r_r0a[4:0];
  assign cursor_end_o   = r_r0b;
  assign start_addr_o   = {r_r0c, r_r0d};

endmodule

// File: tb/tb_vdu_crtc.sv
// Directed bench for vdu_crtc: register decode, row/column conversion,
// saturation, cursor hiding, latency, trigger coalescing and reset abort.
module tb_vdu_crtc;

  logic        clk;
  logic        rst;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic [15:0] vdu_dat_o;
  logic        vdu_we_o;
  logic        vdu_tga_o;
  logic [1:0]  vdu_sel_o;
  logic        vdu_stb_o;
  logic        vdu_cyc_o;
  logic        vdu_ack_i;
  logic [4:0]  cursor_start_o;
  logic [4:0]  cursor_end_o;
  logic [13:0] start_addr_o;
  logic        busy_o;

  int checks;
  int failures;

  vdu_crtc #(.COLS(7'd80), .HIDE_POS(12'hFFF)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .wb_dat_i       (wb_dat_i),
    .wb_dat_o       (wb_dat_o),
    .wb_sel_i       (wb_sel_i),
    .wb_we_i        (wb_we_i),
    .wb_stb_i       (wb_stb_i),
    .wb_cyc_i       (wb_cyc_i),
    .wb_ack_o       (wb_ack_o),
    .vdu_dat_o      (vdu_dat_o),
    .vdu_we_o       (vdu_we_o),
    .vdu_tga_o      (vdu_tga_o),
    .vdu_sel_o      (vdu_sel_o),
    .vdu_stb_o      (vdu_stb_o),
    .vdu_cyc_o      (vdu_cyc_o),
    .vdu_ack_i      (vdu_ack_i),
    .cursor_start_o (cursor_start_o),
    .cursor_end_o   (cursor_end_o),
    .start_addr_o   (start_addr_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One CPU bus cycle; returns 1 time unit after the edge that raised ack.
  task automatic cpu_access(input logic we, input logic [1:0] sel,
                            input logic [7:0] idx, input logic [7:0] dat);
    logic got;
    got = 1'b0;
    wb_we_i  = we;
    wb_sel_i = sel;
    wb_dat_i = {dat, idx};
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin
        got = 1'b1;
        break;
      end
    end
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL cpu_ack_timeout idx=%h got_ack=0 want=1", idx);
    end
  endtask

  // Acknowledge every VDU write until the FSM has been idle for a few cycles.
  task automatic serve_vdu(output int n, output logic [15:0] first,
                           output logic [15:0] last);
    int idle;
    n = 0;
    idle = 0;
    first = 16'hxxxx;
    last = 16'hxxxx;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (vdu_stb_o) begin
        if (n == 0) first = vdu_dat_o;
        last = vdu_dat_o;
        n++;
        vdu_ack_i = 1'b1;
        @(posedge clk); #1;
        vdu_ack_i = 1'b0;
        idle = 0;
      end else if (!busy_o) begin
        idle++;
        if (idle > 3) break;
      end else begin
        idle = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (wb_ack_o !== 1'b0) begin
      failures++; $display("FAIL reset_ack got=%b want=0", wb_ack_o);
    end
    checks++;
    if ({vdu_stb_o, vdu_cyc_o, busy_o} !== 3'b000) begin
      failures++; $display("FAIL reset_stb_cyc_busy got=%b want=000", {vdu_stb_o, vdu_cyc_o, busy_o});
    end
    checks++;
    if (vdu_dat_o !== 16'h0000) begin
      failures++; $display("FAIL reset_vdu_dat got=%h want=0000", vdu_dat_o);
    end
    cpu_access(1'b0, 2'b11, 8'h00, 8'h00);
    checks++;
    if (wb_dat_o !== 16'h0000) begin
      failures++; $display("FAIL reset_read got=%h want=0000", wb_dat_o);
    end
  endtask

  task automatic test_rowcol();
    int n;
    logic [15:0] f, l;
    cpu_access(1'b1, 2'b11, 8'h0E, 8'h07);
    cpu_access(1'b1, 2'b11, 8'h0F, 8'hD0);
    serve_vdu(n, f, l);
    checks++;
    if (n !== 2) begin
      failures++; $display("FAIL rowcol_count got=%0d want=2", n);
    end
    checks++;
    if (f !== 16'h1620) begin
      failures++; $display("FAIL rowcol_1792 got=%h want=1620", f);
    end
    checks++;
    if (l !== 16'h1900) begin
      failures++; $display("FAIL rowcol_2000 got=%h want=1900", l);
    end
  endtask

  task automatic test_latency();
    int n;
    int lat;
    logic [15:0] f, l;
    logic held;
    cpu_access(1'b1, 2'b11, 8'h0E, 8'h00);
    serve_vdu(n, f, l);
    checks++;
    if (l !== 16'h0230) begin
      failures++; $display("FAIL addr208 got=%h want=0230", l);
    end
    cpu_access(1'b1, 2'b11, 8'h0F, 8'h53);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (vdu_stb_o) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 10) begin
      failures++; $display("FAIL latency got=%0d want=10", lat);
    end
    checks++;
    if (vdu_dat_o !== 16'h0103) begin
      failures++; $display("FAIL addr83 got=%h want=0103", vdu_dat_o);
    end
    checks++;
    if ({vdu_cyc_o, vdu_we_o, vdu_tga_o, vdu_sel_o} !== 5'b11111) begin
      failures++; $display("FAIL master_ctrl got=%b want=11111", {vdu_cyc_o, vdu_we_o, vdu_tga_o, vdu_sel_o});
    end
    held = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!vdu_stb_o) held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) begin
      failures++; $display("FAIL stb_hold got=%b want=1", held);
    end
    vdu_ack_i = 1'b1;
    @(posedge clk); #1;
    vdu_ack_i = 1'b0;
    checks++;
    if ({vdu_stb_o, vdu_cyc_o, busy_o} !== 3'b001) begin
      failures++; $display("FAIL done_gap got=%b want=001", {vdu_stb_o, vdu_cyc_o, busy_o});
    end
    @(posedge clk); #1;
    checks++;
    if ({vdu_stb_o, busy_o} !== 2'b00) begin
      failures++; $display("FAIL back_idle got=%b want=00", {vdu_stb_o, busy_o});
    end
  endtask

  task automatic test_saturation();
    int n;
    logic [15:0] f, l;
    cpu_access(1'b1, 2'b11, 8'h0E, 8'h3F);
    cpu_access(1'b1, 2'b11, 8'h0F, 8'hFF);
    serve_vdu(n, f, l);
    checks++;
    if (l !== 16'h1F00) begin
      failures++; $display("FAIL saturate got=%h want=1F00", l);
    end
  endtask

  task automatic test_registers();
    int n;
    logic [15:0] f, l;
    cpu_access(1'b1, 2'b11, 8'h0A, 8'h20);
    serve_vdu(n, f, l);
    checks++;
    if (n !== 1 || l !== 16'h1F7F) begin
      failures++; $display("FAIL cursor_off got=%0d/%h want=1/1F7F", n, l);
    end
    checks++;
    if (cursor_start_o !== 5'h00) begin
      failures++; $display("FAIL cursor_start got=%h want=00", cursor_start_o);
    end
    checks++;
    if (wb_dat_o !== 16'h200A) begin
      failures++; $display("FAIL read_r0a got=%h want=200A", wb_dat_o);
    end
    // index lane only: data lane must be ignored
    cpu_access(1'b1, 2'b01, 8'h0B, 8'hFF);
    checks++;
    if (wb_dat_o !== 16'h000B || cursor_end_o !== 5'h00) begin
      failures++; $display("FAIL index_only got=%h/%h want=000B/00", wb_dat_o, cursor_end_o);
    end
    // data lane only: uses current index, R0B keeps 5 bits
    cpu_access(1'b1, 2'b10, 8'h00, 8'hEE);
    checks++;
    if (wb_dat_o !== 16'h0E0B || cursor_end_o !== 5'h0E) begin
      failures++; $display("FAIL data_only got=%h/%h want=0E0B/0E", wb_dat_o, cursor_end_o);
    end
    cpu_access(1'b1, 2'b11, 8'h0C, 8'h15);
    cpu_access(1'b1, 2'b11, 8'h0D, 8'hAB);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (start_addr_o !== 14'h15AB || busy_o !== 1'b0) begin
      failures++; $display("FAIL start_addr got=%h/%b want=15AB/0", start_addr_o, busy_o);
    end
    cpu_access(1'b1, 2'b11, 8'h05, 8'h77);
    checks++;
    if (wb_dat_o !== 16'h0005) begin
      failures++; $display("FAIL unimpl_read got=%h want=0005", wb_dat_o);
    end
    cpu_access(1'b1, 2'b11, 8'h0A, 8'h00);
    serve_vdu(n, f, l);
    checks++;
    if (l !== 16'h1F00) begin
      failures++; $display("FAIL cursor_on got=%h want=1F00", l);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [15:0] f, l;
    cpu_access(1'b1, 2'b11, 8'h0E, 8'h00);
    serve_vdu(n, f, l);
    checks++;
    if (l !== 16'h030F) begin
      failures++; $display("FAIL addr255 got=%h want=030F", l);
    end
    cpu_access(1'b1, 2'b11, 8'h0F, 8'h10);
    repeat (3) @(posedge clk);
    #1;
    cpu_access(1'b1, 2'b11, 8'h0F, 8'h20);
    cpu_access(1'b1, 2'b11, 8'h0F, 8'hA5);
    serve_vdu(n, f, l);
    checks++;
    if (n !== 2) begin
      failures++; $display("FAIL coalesce_count got=%0d want=2", n);
    end
    checks++;
    if (f !== 16'h0010 || l !== 16'h0205) begin
      failures++; $display("FAIL coalesce_data got=%h/%h want=0010/0205", f, l);
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    cpu_access(1'b1, 2'b11, 8'h0F, 8'h50);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (vdu_stb_o) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (seen !== 1'b1 || vdu_dat_o !== 16'h0100) begin
      failures++; $display("FAIL pre_abort got=%b/%h want=1/0100", seen, vdu_dat_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({vdu_stb_o, vdu_cyc_o} !== 2'b00) begin
      failures++; $display("FAIL abort_same_cycle got=%b want=00", {vdu_stb_o, vdu_cyc_o});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy_o, vdu_dat_o, wb_dat_o, start_addr_o} !== 47'd0) begin
      failures++; $display("FAIL abort_state busy=%b vdat=%h rdat=%h sa=%h want=0", busy_o, vdu_dat_o, wb_dat_o, start_addr_o);
    end
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (vdu_stb_o || busy_o) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL abort_quiet got=%b want=0", seen);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    wb_dat_i  = '0;
    wb_sel_i  = '0;
    wb_we_i   = 1'b0;
    wb_stb_i  = 1'b0;
    wb_cyc_i  = 1'b0;
    vdu_ack_i = 1'b0;
    test_reset();
    test_rowcol();
    test_latency();
    test_saturation();
    test_registers();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
